// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU control
// FSM (default priority) and a host debug/loader port. A saturating wait
// counter forces a host slot after STARVE_LIMIT losing cycles.
module mem_port_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_HOST} owner_e;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    owner_e        owner_q, owner_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          pending_q, pending_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;

    logic cpu_req;
    logic cpu_gnt;

    // Grant decision and memory-side mux; everything is gated off while reset is low.
    always_comb begin
        cpu_req   = cpu_rd | cpu_wr;
        host_gnt  = 1'b0;
        cpu_gnt   = 1'b0;
        cpu_stall = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (reset) begin
            // Forced slot once the host has waited long enough, otherwise CPU first.
            host_gnt  = host_req && ((wait_cnt_q == LIMIT) || !cpu_req);
            cpu_gnt   = cpu_req && !host_gnt;
            cpu_stall = cpu_req && host_gnt;
        end
        if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
            mem_re    = !host_we;
        end else if (cpu_gnt) begin
            // Simultaneous read+write from the FSM resolves as a write.
            mem_we = cpu_wr;
            mem_re = cpu_rd && !cpu_wr;
        end
    end

    // CPU read data comes straight from the macro so FSM timing is unchanged.
    assign cpu_rdata = mem_rdata;

    // The host read pulse is the registered pending flag; data is shown live
    // from the macro in that cycle (it is only valid then) and held afterwards.
    assign host_rvalid = pending_q;
    assign host_rdata  = (pending_q && owner_q == OWN_HOST) ? mem_rdata : host_rdata_q;

    // Next-state: owner tracking, starvation counter, host read bookkeeping.
    always_comb begin
        owner_d      = owner_q;
        wait_cnt_d   = 8'd0;
        pending_d    = host_gnt && !host_we;
        host_rdata_d = host_rdata;
        if (host_gnt)     owner_d = OWN_HOST;
        else if (cpu_gnt) owner_d = OWN_CPU;
        if (host_req && !host_gnt)
            wait_cnt_d = (wait_cnt_q < LIMIT) ? wait_cnt_q + 8'd1 : LIMIT;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q      <= OWN_IDLE;
            wait_cnt_q   <= 8'd0;
            pending_q    <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            owner_q      <= owner_d;
            wait_cnt_q   <= wait_cnt_d;
            pending_q    <= pending_d;
            host_rdata_q <= host_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural memory + arbitration model is
// checked against the DUT every cycle, plus directed literal checks.
module tb_mem_port_arbiter;

    localparam int LIMIT = 8;

    logic       clock, reset;
    logic       cpu_rd, cpu_wr;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_stall;
    logic [7:0] cpu_rdata;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_we, mem_re;
    logic [7:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'h5A : 8'(a * 8'd37 + 8'd11);
    endfunction

    // Synchronous-read memory macro stand-in.
    logic [7:0] env_mem [256];
    logic [7:0] env_rdata;
    logic       preloaded = 1'b0;
    assign mem_rdata = env_rdata;
    always @(posedge clock) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_val(8'(i));
            preloaded <= 1'b1;
        end else begin
            if (mem_we) env_mem[mem_addr] <= mem_wdata;
            if (mem_re) env_rdata <= env_mem[mem_addr];
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the memory this cycle, what the memory holds,
    // and what the previous cycle's read must have returned.
    logic [7:0] m_mem [256];
    int         m_wait;
    logic       m_prev_rd, m_prev_host;
    logic [7:0] m_prev_val, m_hrd;

    initial begin
        logic       creq, hwin, e_we, e_re;
        logic [7:0] e_addr, e_wd;
        for (int i = 0; i < 256; i++) m_mem[i] = init_val(8'(i));
        m_wait = 0; m_prev_rd = 0; m_prev_host = 0; m_prev_val = 0; m_hrd = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                m_wait = 0; m_prev_rd = 0; m_prev_host = 0; m_hrd = 0;
                chk1("rst_stall", cpu_stall, 1'b0);
                chk1("rst_gnt", host_gnt, 1'b0);
                chk1("rst_we", mem_we, 1'b0);
                chk1("rst_re", mem_re, 1'b0);
                chk1("rst_rvalid", host_rvalid, 1'b0);
                chk8("rst_hrdata", host_rdata, 8'h00);
                chk8("rst_cpu_rdata", cpu_rdata, mem_rdata);
            end else begin
                if (m_prev_host) m_hrd = m_prev_val;
                chk1("m_rvalid", host_rvalid, m_prev_host);
                chk8("m_hrdata", host_rdata, m_hrd);
                if (m_prev_rd) chk8("m_rd_data", cpu_rdata, m_prev_val);
                chk8("m_passthru", cpu_rdata, mem_rdata);

                creq = cpu_rd || cpu_wr;
                hwin = host_req && (m_wait >= LIMIT || !creq);
                e_we = 1'b0; e_re = 1'b0; e_addr = cpu_addr; e_wd = cpu_wdata;
                if (hwin) begin
                    e_addr = host_addr; e_wd = host_wdata;
                    e_we = host_we; e_re = !host_we;
                end else if (creq) begin
                    e_we = cpu_wr; e_re = !cpu_wr;
                end
                chk1("m_gnt", host_gnt, hwin);
                chk1("m_stall", cpu_stall, creq && hwin);
                chk1("m_we", mem_we, e_we);
                chk1("m_re", mem_re, e_re);
                chk8("m_addr", mem_addr, e_addr);
                if (e_we) chk8("m_wdata", mem_wdata, e_wd);

                m_prev_rd   = e_re;
                m_prev_host = hwin && e_re;
                m_prev_val  = m_mem[e_addr];
                if (e_we) m_mem[e_addr] = e_wd;
                if (host_req && !hwin) m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
                else m_wait = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic new_host();
        host_req   = 1'b1;
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = 8'($urandom_range(0, 15));
        host_wdata = 8'($urandom);
    endtask

    initial begin
        logic g;
        reset = 1'b0;
        cpu_rd = 0; cpu_wr = 1; cpu_addr = 8'h01; cpu_wdata = 8'hEE;
        host_req = 1; host_we = 1; host_addr = 8'h02; host_wdata = 8'hDD;
        repeat (3) tick();
        cpu_wr = 0; host_req = 0; host_we = 0;
        reset = 1'b1;

        // CPU only read of 0x10.
        cpu_rd = 1; cpu_addr = 8'h10;
        sample();
        chk1("cpu_re", mem_re, 1'b1);
        chk8("cpu_addr", mem_addr, 8'h10);
        chk1("cpu_nostall", cpu_stall, 1'b0);
        tick(); cpu_rd = 0;
        sample();
        chk8("cpu_rdata_5a", cpu_rdata, 8'h5A);
        chk1("cpu_nostall2", cpu_stall, 1'b0);
        tick();

        // Host write then read of 0x20.
        host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'hC3;
        sample();
        chk1("hw_gnt", host_gnt, 1'b1);
        chk1("hw_we", mem_we, 1'b1);
        tick(); host_we = 0;
        sample();
        chk1("hr_gnt", host_gnt, 1'b1);
        chk1("hr_re", mem_re, 1'b1);
        tick(); host_req = 0;
        sample();
        chk1("hr_rvalid", host_rvalid, 1'b1);
        chk8("hr_rdata", host_rdata, 8'hC3);
        tick();

        // Contention: forced host slot on the 9th cycle, CPU back on the 10th.
        cpu_rd = 1; cpu_addr = 8'h05;
        host_req = 1; host_we = 0; host_addr = 8'h10;
        for (int c = 1; c <= 10; c++) begin
            sample();
            chk1($sformatf("cont_gnt_%0d", c), host_gnt, c == 9);
            chk1($sformatf("cont_stall_%0d", c), cpu_stall, c == 9);
            if (c == 10) begin
                chk8("cont_addr", mem_addr, 8'h05);
                chk1("cont_rvalid", host_rvalid, 1'b1);
                chk8("cont_rdata", host_rdata, 8'h5A);
            end
            tick();
        end
        cpu_rd = 0; host_req = 0;

        // Simultaneous read+write: write wins.
        cpu_rd = 1; cpu_wr = 1; cpu_addr = 8'h03; cpu_wdata = 8'h77;
        sample();
        chk1("rw_we", mem_we, 1'b1);
        chk1("rw_re", mem_re, 1'b0);
        tick(); cpu_wr = 0;
        sample();
        tick(); cpu_rd = 0;
        sample();
        chk8("rw_readback", cpu_rdata, 8'h77);
        tick();

        // Withdrawn host request restarts the starvation count.
        cpu_rd = 1; cpu_addr = 8'h07; host_req = 1; host_we = 0; host_addr = 8'h08;
        for (int c = 0; c < 5; c++) begin
            sample(); chk1("wd_early_gnt", host_gnt, 1'b0); tick();
        end
        host_req = 0;
        sample(); chk1("wd_drop_gnt", host_gnt, 1'b0); tick();
        host_req = 1;
        for (int c = 1; c <= 9; c++) begin
            sample(); chk1($sformatf("wd_gnt_%0d", c), host_gnt, c == 9); tick();
        end
        cpu_rd = 0; host_req = 0;

        // Reset lands on the edge ending a host read grant.
        host_req = 1; host_we = 0; host_addr = 8'h20;
        sample();
        chk1("rr_gnt", host_gnt, 1'b1);
        #1 reset = 1'b0;
        tick(); host_req = 0; cpu_wr = 1; cpu_addr = 8'h09;
        sample();
        chk1("rr_rvalid", host_rvalid, 1'b0);
        chk1("rr_we", mem_we, 1'b0);
        chk1("rr_re", mem_re, 1'b0);
        tick();
        sample();
        chk1("rr_rvalid2", host_rvalid, 1'b0);
        chk8("rr_rdata", host_rdata, 8'h00);
        tick(); cpu_wr = 0; reset = 1'b1;

        // Randomized traffic, host holds its request until granted.
        g = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            cpu_rd    = ($urandom_range(0, 9) < 6);
            cpu_wr    = ($urandom_range(0, 9) < 2);
            cpu_addr  = 8'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
            if (!host_req) begin
                if ($urandom_range(0, 9) < 3) new_host();
            end else if (g) begin
                if ($urandom_range(0, 1) == 1) new_host();
                else host_req = 1'b0;
            end else if ($urandom_range(0, 99) < 3) begin
                host_req = 1'b0;
            end
            sample();
            g = host_gnt;
            tick();
        end
        cpu_rd = 0; cpu_wr = 0; host_req = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter for the processor's single-port data/instruction memory. It shares the memory between two requesters: the multicycle control FSM (CPU port) and a host debug/loader port (host port). The CPU has default priority. A starvation counter guarantees the host a slot. The block sits between the FSM/datapath memory signals and the memory macro, and feeds a stall back to the FSM.

## Interface
Parameters:
- AW, 8, address width
- DW, 8, data width
- STARVE_LIMIT, 8, host wait cycles before forced host grant (1..255)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_rd  in  1  CPU read request (FSM MemRead)
- cpu_wr  in  1  CPU write request (FSM MemWrite)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_stall  out  1  CPU request not serviced this cycle; FSM must hold its state
- cpu_rdata  out  DW  memory read data to MDR/IR
- host_req  in  1  host access request, level, held until granted
- host_we  in  1  host write (1) / read (0)
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host access performed this cycle
- host_rvalid  out  1  host read data valid (registered)
- host_rdata  out  DW  host read data (registered)
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rdata  in  DW  memory read data; valid the cycle after mem_re

## Operation
- A CPU request is cpu_rd|cpu_wr. If both are high, the write wins: mem_we=1 and mem_re=0.
- Grant is decided combinationally each cycle from the current inputs and the registered state.
- State register owner ∈ {IDLE, CPU, HOST}. It records the last granted requester and is used only for rdata steering and debug.
- Registered wait_cnt, 8 bits:
  - +1 each cycle host_req=1 and host_gnt=0; saturates at STARVE_LIMIT.
  - Clears on host_gnt or when host_req=0.
- Grant rules:
  - host_req=1 and wait_cnt==STARVE_LIMIT: host granted; CPU stalled if it is requesting.
  - else CPU request: CPU granted; host waits.
  - else host_req=1: host granted.
  - else: idle, with mem_we=mem_re=0 and mem_addr=cpu_addr.
- mem_addr/mem_wdata/mem_we/mem_re are muxed from the granted requester.
- cpu_stall = CPU request and host granted.
- cpu_rdata = mem_rdata (pass-through).
- Host read: when host_gnt and !host_we, a registered pending flag is set. Next cycle host_rvalid=1 and host_rdata captures mem_rdata (one-cycle pulse).
- After a forced host grant, wait_cnt=0, so the CPU wins the following cycle and the host cannot starve the CPU.
- Host back-to-back requests: each cycle host_req stays high counts as a new access after the previous grant.

## Timing
- All registers reset asynchronously when reset=0: owner=IDLE, wait_cnt=0, pending=0, host_rvalid=0, host_rdata=0.
- Combinational outputs during reset:
  - cpu_stall=0, host_gnt=0, mem_we=0, mem_re=0 regardless of inputs.
  - cpu_rdata follows mem_rdata.
- CPU path latency: 0 cycles added when not stalled. Memory timing is identical to a direct FSM connection.
- Host read latency: host_gnt at cycle t, host_rvalid/host_rdata at cycle t+1.
- Host write latency: the write is committed at the clock edge ending the host_gnt cycle.
- Worst-case host wait with the CPU requesting continuously: STARVE_LIMIT cycles, then granted.
- Worst-case CPU stall: 1 cycle per forced host grant.
- Reset asserted mid-host-read: pending is cleared and no host_rvalid pulse is issued.
- host_req dropped before grant: wait_cnt clears and no access occurs.

## Test plan
- CPU only: cpu_rd, cpu_addr=0x10, memory holds 0x5A -> mem_re=1 and mem_addr=0x10 same cycle; cpu_rdata=0x5A next cycle; cpu_stall=0 throughout.
- Host only: host_req, host_we=1, addr=0x20, wdata=0xC3; then host read of 0x20 -> host_gnt in the first cycle of each; host_rvalid=1 with host_rdata=0xC3 one cycle after the read grant.
- Contention: cpu_rd held continuously, host_req held, STARVE_LIMIT=8 -> host_gnt=0 for 8 cycles; on the 9th cycle host_gnt=1 and cpu_stall=1; in the 10th cycle the CPU is granted and cpu_stall=0.
- Simultaneous cpu_rd=cpu_wr=1, addr=0x03, wdata=0x77 -> mem_we=1 and mem_re=0; a subsequent read of 0x03 returns 0x77.
- Reset mid-operation: host read granted, reset=0 on the next edge -> host_rvalid stays 0; all registers at reset values; mem_we/mem_re=0 while reset is low.
- Withdrawn host request: host_req high 5 cycles under CPU load, then low -> wait_cnt returns to 0; the host must then wait a fresh 8 cycles before a forced grant.
